process_scheduler: RTL

- Round-robin preemptive process scheduler for the single-cycle MIPS core.
- Sequences context switches when the preemption timer fires its interrupt or the running process yields.
- Keeps a ready mask of user processes and drives the current process ID seen by the datapath and timer.
- Handshakes with the context save/restore unit, and holds the timer blocked and then resets it around every switch.

---
 rtl/process_scheduler_if.sv | 36 +++
 rtl/process_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/process_scheduler_if.sv
// Scheduler-side bundle: switch requests, ready-mask updates, context
// save/restore handshake and timer/datapath control outputs.
interface process_scheduler_if #(
  parameter int PID_W = 32
);
  logic             interrupt;
  logic             yield;
  logic             createValid;
  logic [PID_W-1:0] createPid;
  logic             killValid;
  logic [PID_W-1:0] killPid;
  logic             saveAck;
  logic             loadAck;
  logic [PID_W-1:0] currentPid;
  logic [PID_W-1:0] nextPid;
  logic             contextSave;
  logic             contextLoad;
  logic             timerBlock;
  logic             timerReset;
  logic             idle;

  // master: the scheduler itself; slave: core, timer and context unit
  modport master (
    input  interrupt, yield, createValid, createPid, killValid, killPid,
           saveAck, loadAck,
    output currentPid, nextPid, contextSave, contextLoad, timerBlock,
           timerReset, idle
  );

  modport slave (
    output interrupt, yield, createValid, createPid, killValid, killPid,
           saveAck, loadAck,
    input  currentPid, nextPid, contextSave, contextLoad, timerBlock,
           timerReset, idle
  );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin preemptive scheduler: tracks runnable PIDs and sequences
// save -> scan -> load context switches on timer interrupt or yield.
module process_scheduler #(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  process_scheduler_if.master  bus
);

  localparam int CNT_W = $clog2(NUM_PROCS + 1);

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    RUN    = 3'd1,
    SAVE   = 3'd2,
    SELECT = 3'd3,
    LOAD   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_PROCS-1:0]  readyMask_q, readyMask_d;
  logic [PID_W-1:0]      currentPid_q, currentPid_d;
  logic [PID_W-1:0]      nextPid_q, nextPid_d;
  logic [PID_W-1:0]      scanPid_q, scanPid_d;
  logic [CNT_W-1:0]      scanCount_q, scanCount_d;
  logic                  timerReset_q, timerReset_d;

  // Out-of-range PIDs (0 or > NUM_PROCS) map to an all-zero mask.
  function automatic logic [NUM_PROCS-1:0] pid_onehot(input logic [PID_W-1:0] pid);
    logic [NUM_PROCS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PROCS; i++)
      if (pid == PID_W'(i + 1)) oh[i] = 1'b1;
    return oh;
  endfunction

  function automatic logic pid_ready(input logic [NUM_PROCS-1:0] mask,
                                     input logic [PID_W-1:0]     pid);
    return |(mask & pid_onehot(pid));
  endfunction

  function automatic logic [PID_W-1:0] pid_wrap_next(input logic [PID_W-1:0] pid);
    return (pid >= PID_W'(NUM_PROCS)) ? PID_W'(1) : pid + PID_W'(1);
  endfunction

  always_comb begin
    readyMask_d  = readyMask_q;
    state_d      = state_q;
    currentPid_d = currentPid_q;
    nextPid_d    = nextPid_q;
    scanPid_d    = scanPid_q;
    scanCount_d  = scanCount_q;
    timerReset_d = 1'b0;

    // Kill is applied after create so it wins on a same-PID collision.
    if (bus.createValid) readyMask_d = readyMask_d | pid_onehot(bus.createPid);
    if (bus.killValid)   readyMask_d = readyMask_d & ~pid_onehot(bus.killPid);

    unique case (state_q)
      EMPTY: begin
        currentPid_d = '0;
        if (|readyMask_d) begin
          state_d     = SELECT;
          scanPid_d   = PID_W'(1);
          scanCount_d = '0;
        end
      end
      RUN: begin
        // Scan always resumes after the outgoing PID, whether or not we save.
        if (!pid_ready(readyMask_q, currentPid_q)) begin
          state_d     = SELECT;
          scanPid_d   = pid_wrap_next(currentPid_q);
          scanCount_d = '0;
        end else if (bus.interrupt || bus.yield) begin
          state_d     = SAVE;
          scanPid_d   = pid_wrap_next(currentPid_q);
          scanCount_d = '0;
        end
      end
      SAVE: begin
        if (bus.saveAck) state_d = SELECT;
      end
      SELECT: begin
        if (pid_ready(readyMask_q, scanPid_q)) begin
          nextPid_d = scanPid_q;
          state_d   = LOAD;
        end else begin
          scanPid_d   = pid_wrap_next(scanPid_q);
          scanCount_d = scanCount_q + CNT_W'(1);
          if (scanCount_q == CNT_W'(NUM_PROCS - 1)) begin
            state_d      = EMPTY;
            currentPid_d = '0;
          end
        end
      end
      LOAD: begin
        if (bus.loadAck) begin
          currentPid_d = nextPid_q;
          timerReset_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      readyMask_q  <= '0;
      currentPid_q <= '0;
      nextPid_q    <= '0;
      scanPid_q    <= '0;
      scanCount_q  <= '0;
      timerReset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      readyMask_q  <= readyMask_d;
      currentPid_q <= currentPid_d;
      nextPid_q    <= nextPid_d;
      scanPid_q    <= scanPid_d;
      scanCount_q  <= scanCount_d;
      timerReset_q <= timerReset_d;
    end
  end

  // Handshake/timer outputs decode the state register so reset clears them at once.
  assign bus.currentPid  = currentPid_q;
  assign bus.nextPid     = nextPid_q;
  assign bus.contextSave = (state_q == SAVE);
  assign bus.contextLoad = (state_q == LOAD);
  assign bus.timerBlock  = (state_q != RUN);
  assign bus.idle        = (state_q == EMPTY);
  assign bus.timerReset  = timerReset_q;

endmodule
